io_bus_arbiter: RTL and testbench

- Shares the single peripheral I/O bus between the J1 core's I/O port (primary master) and one secondary master, e.g. the ultrasonic capture engine acting as a DMA.
- The CPU I/O port cannot stall, so it always wins with zero added latency (pure combinational pass-through).
- The secondary master uses a req/ack handshake and is served only in cycles where the CPU is idle on the bus.
- Sits between j1 io_* signals and the peripheral address decoder.

---
 rtl/io_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the peripheral I/O bus between the J1 CPU I/O port
// (primary master, combinational pass-through) and a secondary req/ack master
// that is served only in cycles where the CPU leaves the bus idle.
// Optional build macro: IO_ARB_WINDOW_EN restricts secondary-master accesses
// to the address window [WIN_LO, WIN_HI] and reports refused ones on dma_err_o.
module io_bus_arbiter #(
    parameter int unsigned STARVE_W   = 8,
    parameter int unsigned STARVE_MAX = 200,
    parameter logic [15:0] WIN_LO     = 16'h4000,
    parameter logic [15:0] WIN_HI     = 16'h7FFF
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    // CPU I/O port
    input  logic        cpu_rd_i,
    input  logic        cpu_wr_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [15:0] cpu_dout_i,
    output logic [15:0] cpu_din_o,
    // Secondary master
    input  logic        dma_req_i,
    input  logic        dma_we_i,
    input  logic [15:0] dma_addr_i,
    input  logic [15:0] dma_dout_i,
    output logic [15:0] dma_din_o,
    output logic        dma_ack_o,
    output logic        dma_err_o,
    output logic        dma_starve_o,
    // Peripheral bus
    output logic        bus_rd_o,
    output logic        bus_wr_o,
    output logic [15:0] bus_addr_o,
    output logic [15:0] bus_dout_o,
    input  logic [15:0] bus_din_i,
    output logic        owner_o
);

    typedef enum logic [1:0] {StIdle, StArm, StAck} state_e;

    localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_MAX);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [15:0]         addr_q, addr_d;
    logic [15:0]         dout_q, dout_d;
    logic [15:0]         din_q, din_d;
    logic [STARVE_W-1:0] cnt_q, cnt_d;
    logic                cpu_act;
    logic                dma_go;   // secondary master owns the bus this cycle
    logic                win_err;  // latched address refused by the window check

    assign cpu_act = cpu_rd_i | cpu_wr_i;

`ifdef IO_ARB_WINDOW_EN
    logic err_q, err_d;

    assign win_err   = (addr_q < WIN_LO) || (addr_q > WIN_HI);
    assign dma_err_o = (state_q == StAck) && err_q;

    // Error flag accompanying the ack of a refused request
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    logic unused_win;

    assign win_err    = 1'b0;
    assign dma_err_o  = 1'b0;
    assign unused_win = ^{WIN_LO, WIN_HI};
`endif

    // State, latched request and wait counter registers
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            din_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, wait for a free bus slot in ARM, pulse ack in ACK
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        dma_go  = 1'b0;
`ifdef IO_ARB_WINDOW_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (dma_req_i) begin
                    we_d    = dma_we_i;
                    addr_d  = dma_addr_i;
                    dout_d  = dma_dout_i;
                    state_d = StArm;
                end
            end
            StArm: begin
                if (win_err) begin
                    // Refused without touching the bus, regardless of CPU activity
                    din_d   = '0;
                    cnt_d   = '0;
                    state_d = StAck;
`ifdef IO_ARB_WINDOW_EN
                    err_d   = 1'b1;
`endif
                end else if (!cpu_act) begin
                    dma_go  = 1'b1;
                    if (!we_q) begin
                        din_d = bus_din_i;
                    end
                    cnt_d   = '0;
                    state_d = StAck;
`ifdef IO_ARB_WINDOW_EN
                    err_d   = 1'b0;
`endif
                end else if (cnt_q != StarveMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bus mux: CPU has absolute priority, the secondary master only fills idle slots
    always_comb begin
        bus_rd_o   = 1'b0;
        bus_wr_o   = 1'b0;
        bus_addr_o = '0;
        bus_dout_o = '0;
        owner_o    = 1'b0;
        if (cpu_act) begin
            bus_rd_o   = cpu_rd_i;
            bus_wr_o   = cpu_wr_i;
            bus_addr_o = cpu_addr_i;
            bus_dout_o = cpu_dout_i;
        end else if (dma_go) begin
            bus_rd_o   = ~we_q;
            bus_wr_o   = we_q;
            bus_addr_o = addr_q;
            bus_dout_o = dout_q;
            owner_o    = 1'b1;
        end
    end

    assign cpu_din_o    = bus_din_i;
    assign dma_din_o    = din_q;
    assign dma_ack_o    = (state_q == StAck);
    assign dma_starve_o = (cnt_q == StarveMax);

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Testbench for io_bus_arbiter: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model.
module tb_io_bus_arbiter;

    localparam int unsigned STARVE_W   = 8;
    localparam int unsigned STARVE_MAX = 200;
    localparam logic [15:0] WIN_LO     = 16'h4000;
    localparam logic [15:0] WIN_HI     = 16'h7FFF;

    logic        clk;
    logic        rst_n;
    logic        cpu_rd, cpu_wr;
    logic [15:0] cpu_addr, cpu_dout;
    logic [15:0] cpu_din;
    logic        dma_req, dma_we;
    logic [15:0] dma_addr, dma_dout;
    logic [15:0] dma_din;
    logic        dma_ack, dma_err, dma_starve;
    logic        bus_rd, bus_wr;
    logic [15:0] bus_addr, bus_dout, bus_din;
    logic        owner;

    io_bus_arbiter #(
        .STARVE_W  (STARVE_W),
        .STARVE_MAX(STARVE_MAX),
        .WIN_LO    (WIN_LO),
        .WIN_HI    (WIN_HI)
    ) dut (
        .sys_clk_i   (clk),
        .sys_rst_i   (rst_n),
        .cpu_rd_i    (cpu_rd),
        .cpu_wr_i    (cpu_wr),
        .cpu_addr_i  (cpu_addr),
        .cpu_dout_i  (cpu_dout),
        .cpu_din_o   (cpu_din),
        .dma_req_i   (dma_req),
        .dma_we_i    (dma_we),
        .dma_addr_i  (dma_addr),
        .dma_dout_i  (dma_dout),
        .dma_din_o   (dma_din),
        .dma_ack_o   (dma_ack),
        .dma_err_o   (dma_err),
        .dma_starve_o(dma_starve),
        .bus_rd_o    (bus_rd),
        .bus_wr_o    (bus_wr),
        .bus_addr_o  (bus_addr),
        .bus_dout_o  (bus_dout),
        .bus_din_i   (bus_din),
        .owner_o     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: one outstanding transaction, tracked as "waiting for a
    // slot" / "ack due", with an unbounded count of cycles lost to the CPU.
    bit          m_pend;
    bit          m_ack;
    bit          m_err;
    logic        m_we;
    logic [15:0] m_addr, m_dout, m_din;
    int          m_wait;
    bit          prev_owner;
    int          ack_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit out_of_window(input logic [15:0] a);
`ifdef IO_ARB_WINDOW_EN
        return (a < WIN_LO) || (a > WIN_HI);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        m_pend = 0; m_ack = 0; m_err = 0; m_we = 0;
        m_addr = '0; m_dout = '0; m_din = '0; m_wait = 0;
        prev_owner = 0;
    endtask

    task automatic check_outputs();
        bit          act;
        bit          drive;
        logic        e_rd, e_wr;
        logic [15:0] e_addr, e_dout;
        act   = cpu_rd | cpu_wr;
        drive = m_pend && !act && !out_of_window(m_addr);
        e_rd = 0; e_wr = 0; e_addr = '0; e_dout = '0;
        if (act) begin
            e_rd = cpu_rd; e_wr = cpu_wr; e_addr = cpu_addr; e_dout = cpu_dout;
        end else if (drive) begin
            e_rd = !m_we; e_wr = m_we; e_addr = m_addr; e_dout = m_dout;
        end
        chk("bus_rd", 32'(bus_rd), 32'(e_rd));
        chk("bus_wr", 32'(bus_wr), 32'(e_wr));
        chk("bus_addr", 32'(bus_addr), 32'(e_addr));
        chk("bus_dout", 32'(bus_dout), 32'(e_dout));
        chk("owner", 32'(owner), 32'(drive));
        chk("cpu_din", 32'(cpu_din), 32'(bus_din));
        chk("ack", 32'(dma_ack), 32'(m_ack));
        if (m_ack) chk("dma_din", 32'(dma_din), 32'(m_din));
        chk("err", 32'(dma_err), 32'(m_ack & m_err));
        chk("starve", 32'(dma_starve), 32'(m_wait >= int'(STARVE_MAX)));
        chk("owner_adj", 32'(prev_owner & owner), 32'd0);
        prev_owner = owner;
        if (dma_ack) ack_seen++;
    endtask

    task automatic model_step();
        bit act;
        act = cpu_rd | cpu_wr;
        if (m_ack) begin
            m_ack = 0;
        end else if (m_pend) begin
            if (out_of_window(m_addr)) begin
                m_pend = 0; m_ack = 1; m_err = 1; m_din = '0; m_wait = 0;
            end else if (!act) begin
                m_pend = 0; m_ack = 1; m_err = 0; m_wait = 0;
                if (!m_we) m_din = bus_din;
            end else begin
                m_wait++;
            end
        end else if (dma_req) begin
            m_pend = 1; m_we = dma_we; m_addr = dma_addr; m_dout = dma_dout;
        end
    endtask

    // One bus cycle: drive at negedge, check mid-cycle, advance model at posedge
    task automatic cycle(input logic crd, input logic cwr, input logic [15:0] caddr,
                         input logic [15:0] cdout, input logic req, input logic we,
                         input logic [15:0] daddr, input logic [15:0] ddout,
                         input logic [15:0] bdin);
        @(negedge clk);
        cpu_rd = crd; cpu_wr = cwr; cpu_addr = caddr; cpu_dout = cdout;
        dma_req = req; dma_we = we; dma_addr = daddr; dma_dout = ddout; bus_din = bdin;
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'($urandom));
    endtask

    task automatic rand_cycles(input int n, input int unsigned cpu_pct);
        for (int i = 0; i < n; i++) begin
            logic act, rd;
            act = ($urandom_range(99) < cpu_pct);
            rd  = 1'($urandom);
            cycle(act & rd, act & ~rd, 16'($urandom), 16'($urandom), 1'($urandom),
                  1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        end
    endtask

    // Reset dropped mid-cycle with the CPU idle: any pending transfer is discarded
    task automatic reset_cycle();
        @(negedge clk);
        cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_dout = '0;
        dma_req = 0; bus_din = 16'hA5A5;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ack", 32'(dma_ack), 32'd0);
        chk("rst_din", 32'(dma_din), 32'd0);
        chk("rst_err", 32'(dma_err), 32'd0);
        chk("rst_starve", 32'(dma_starve), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_bus", 32'({bus_rd, bus_wr, bus_addr, bus_dout} != 0), 32'd0);
        model_clear();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_rd = 1; cpu_wr = 0; cpu_addr = 16'h1234; cpu_dout = 16'h5678;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_dout = '0; bus_din = 16'h9ABC;
        model_clear();
        ack_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        // CPU pass-through and quiet DMA outputs while held in reset
        chk("rst_cpu_rd", 32'(bus_rd), 32'd1);
        chk("rst_cpu_addr", 32'(bus_addr), 32'h1234);
        chk("rst_cpu_din", 32'(cpu_din), 32'h9ABC);
        chk("rst0_ack", 32'(dma_ack), 32'd0);
        chk("rst0_din", 32'(dma_din), 32'd0);
        chk("rst0_starve", 32'(dma_starve), 32'd0);
        cpu_rd = 0;
        #1 rst_n = 1'b1;

        // Minimum-latency read
        cycle(0, 0, 16'h0, 16'h0, 1, 0, 16'h4002, 16'h0, 16'h0000);
        cycle(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'hBEEF);
        cycle(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0000);
        idle_cycles(2);

        // Write held off by three CPU writes
        cycle(0, 1, 16'h6000, 16'h0001, 1, 1, 16'h4010, 16'h1234, 16'h0);
        cycle(0, 1, 16'h6000, 16'h0002, 0, 0, 16'h0, 16'h0, 16'h0);
        cycle(0, 1, 16'h6000, 16'h0003, 0, 0, 16'h0, 16'h0, 16'h0);
        idle_cycles(3);

        // Starvation: CPU read held for 205 cycles with a request pending
        cycle(1, 0, 16'h2000, 16'h0, 1, 0, 16'h5000, 16'h0, 16'h1111);
        for (int i = 0; i < 205; i++) cycle(1, 0, 16'(i), 16'h0, 0, 0, 16'h0, 16'h0, 16'(i));
        idle_cycles(3);

        // Reset in the transfer slot of a pending read
        cycle(0, 0, 16'h0, 16'h0, 1, 0, 16'h4100, 16'h0, 16'h0);
        reset_cycle();
        idle_cycles(3);
        cycle(0, 0, 16'h0, 16'h0, 1, 1, 16'h4200, 16'hCAFE, 16'h0);
        idle_cycles(3);

        // Back-to-back requests: one ack every third cycle
        ack_seen = 0;
        for (int i = 0; i < 30; i++) cycle(0, 0, 16'h0, 16'h0, 1, 0, 16'h4000 + 16'(i), 16'h0, 16'($urandom));
        chk("ack_rate", 32'(ack_seen), 32'd10);
        idle_cycles(3);

        // Out-of-window read: refused with the macro, normal without it
        cycle(0, 0, 16'h0, 16'h0, 1, 0, 16'h8000, 16'h0, 16'h0);
        cycle(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h7777);
        cycle(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
        idle_cycles(2);

        // Randomized traffic at light and heavy CPU load
        rand_cycles(400, 50);
        rand_cycles(400, 95);
        rand_cycles(200, 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
